// File: rtl/mmu_port_arbiter_pkg.sv
// mmu_port_arbiter_pkg: shared definitions for the MMU port arbiter.
// Holds the arbiter FSM state encodings, requester IDs and the watchdog default.
// These live next to the pipeline exception and hazard codes used elsewhere in the core.
package mmu_port_arbiter_pkg;

  // Pipeline exception cause codes.
  localparam logic [3:0] ExcInstrAccessFault = 4'd1;
  localparam logic [3:0] ExcLoadAccessFault  = 4'd5;
  localparam logic [3:0] ExcStoreAccessFault = 4'd7;

  // Hazard unit request codes.
  localparam logic [1:0] HazNone     = 2'd0;
  localparam logic [1:0] HazStall    = 2'd1;
  localparam logic [1:0] HazFlushAll = 2'd2;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StGntI  = 2'd1,
    StGntD  = 2'd2,
    StDrain = 2'd3
  } arb_state_e;

  // Owner of the shared walker/memory port.
  typedef enum logic {
    ReqImem = 1'b0,
    ReqDmem = 1'b1
  } req_id_e;

  // Watchdog limit used when ARB_TIMEOUT_EN is defined.
  localparam int unsigned TimeoutCyclesDefault = 256;

endpackage

// File: rtl/arb_timeout_ctr.sv
// arb_timeout_ctr: watchdog for one shared-port transaction.
// Counts cycles while i_run is high; o_expired flags the last allowed cycle so the
// arbiter can abandon the request on that edge. Cleared whenever i_run is low.
// Ports: clk, rst (async active-high), i_run (m_req active), o_expired.
// Only instantiated when ARB_TIMEOUT_EN is defined.
module arb_timeout_ctr #(
  parameter int unsigned LIMIT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  output logic o_expired
);

  localparam int unsigned CntW = $clog2(LIMIT + 1);

  logic [CntW-1:0] r_cnt;

  // Cycle index of the current m_req-high cycle; expiry on index LIMIT-1 gives
  // exactly LIMIT cycles of m_req.
  assign o_expired = i_run && (r_cnt == CntW'(LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!i_run) begin
      r_cnt <= '0;
    end else if (!o_expired) begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

endmodule

// File: rtl/mmu_port_arbiter.sv
// mmu_port_arbiter: arbitrates IMEM and DMEM MMU requests onto one walker/memory port.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   i_req/i_addr           IMEM request (held until i_ack); i_ack/i_rdata/i_fault response
//   d_req/d_we/d_addr/d_wdata  DMEM request; d_ack/d_rdata/d_fault response
//   flush                  FLUSH_ALL from hazard unit (cancels an in-flight IMEM request)
//   m_req/m_we/m_addr/m_wdata  shared port request; m_ready/m_rdata/m_fault completion
//   stall_IMEM, stall_DMEM stall requests to hazard unit
// DMEM has priority unless IMEM has been passed over STARVE_LIMIT times in a row.
// Optional watchdog: define ARB_TIMEOUT_EN to abandon a request after TIMEOUT_CYCLES.
module mmu_port_arbiter
  import mmu_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDefault
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  output logic        i_fault,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_fault,
  input  logic        flush,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ready,
  input  logic [31:0] m_rdata,
  input  logic        m_fault,
  output logic        stall_IMEM,
  output logic        stall_DMEM
);

  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

  arb_state_e         r_state;
  req_id_e            r_owner;
  logic [StarveW-1:0] r_starve;
  logic               r_m_req;
  logic               r_m_we;
  logic [31:0]        r_m_addr;
  logic [31:0]        r_m_wdata;
  logic               r_i_ack;
  logic [31:0]        r_i_rdata;
  logic               r_i_fault;
  logic               r_d_ack;
  logic [31:0]        r_d_rdata;
  logic               r_d_fault;

  logic w_timeout;
  logic w_ack_busy;
  logic w_grant_d;
  logic w_grant_i;

`ifdef ARB_TIMEOUT_EN
  arb_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .i_run     (r_m_req),
    .o_expired (w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  // While an ack is pulsing the acked requester still shows req high; grants wait a
  // cycle so that stale request is never served twice.
  assign w_ack_busy = r_i_ack | r_d_ack;
  assign w_grant_d  = d_req && (!i_req || (r_starve < StarveW'(STARVE_LIMIT)));
  assign w_grant_i  = i_req && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_owner   <= ReqImem;
      r_starve  <= '0;
      r_m_req   <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
      r_i_ack   <= 1'b0;
      r_i_rdata <= '0;
      r_i_fault <= 1'b0;
      r_d_ack   <= 1'b0;
      r_d_rdata <= '0;
      r_d_fault <= 1'b0;
    end else begin
      r_i_ack <= 1'b0;
      r_d_ack <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (!w_ack_busy) begin
            if (w_grant_d) begin
              r_state   <= StGntD;
              r_owner   <= ReqDmem;
              r_m_req   <= 1'b1;
              r_m_we    <= d_we;
              r_m_addr  <= d_addr;
              r_m_wdata <= d_wdata;
              if (i_req && (r_starve != StarveW'(STARVE_LIMIT))) begin
                r_starve <= r_starve + StarveW'(1);
              end
            end else if (w_grant_i) begin
              r_state   <= StGntI;
              r_owner   <= ReqImem;
              r_m_req   <= 1'b1;
              r_m_we    <= 1'b0;
              r_m_addr  <= i_addr;
              r_m_wdata <= '0;
              r_starve  <= '0;
            end
          end
        end
        StGntI: begin
          if (m_ready) begin
            // Completion wins over a simultaneous flush.
            r_state   <= StIdle;
            r_m_req   <= 1'b0;
            r_i_ack   <= 1'b1;
            r_i_fault <= m_fault;
            r_i_rdata <= m_fault ? 32'h0 : m_rdata;
          end else if (w_timeout) begin
            r_state   <= StIdle;
            r_m_req   <= 1'b0;
            r_i_ack   <= 1'b1;
            r_i_fault <= 1'b1;
            r_i_rdata <= '0;
          end else if (flush) begin
            r_state <= StDrain;
          end
        end
        StGntD: begin
          if (m_ready) begin
            r_state   <= StIdle;
            r_m_req   <= 1'b0;
            r_d_ack   <= 1'b1;
            r_d_fault <= m_fault;
            r_d_rdata <= m_fault ? 32'h0 : m_rdata;
          end else if (w_timeout) begin
            r_state   <= StIdle;
            r_m_req   <= 1'b0;
            r_d_ack   <= 1'b1;
            r_d_fault <= 1'b1;
            r_d_rdata <= '0;
          end
        end
        StDrain: begin
          // Flushed IMEM request: keep the port request until it completes, drop the data.
          if (m_ready || w_timeout) begin
            r_state <= StIdle;
            r_m_req <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign m_req      = r_m_req;
  assign m_we       = r_m_we;
  assign m_addr     = r_m_addr;
  assign m_wdata    = r_m_wdata;
  assign i_ack      = r_i_ack;
  assign i_rdata    = r_i_rdata;
  assign i_fault    = r_i_fault;
  assign d_ack      = r_d_ack;
  assign d_rdata    = r_d_rdata;
  assign d_fault    = r_d_fault;
  assign stall_IMEM = i_req & ~r_i_ack;
  assign stall_DMEM = d_req & ~r_d_ack;

endmodule

// File: tb/tb_mmu_port_arbiter.sv
// tb_mmu_port_arbiter: directed, table-driven bench for mmu_port_arbiter.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mmu_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        i_fault;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_fault;
  logic        flush;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ready;
  logic [31:0] m_rdata;
  logic        m_fault;
  logic        stall_IMEM;
  logic        stall_DMEM;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mmu_port_arbiter #(
    .STARVE_LIMIT   (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_ack      (i_ack),
    .i_rdata    (i_rdata),
    .i_fault    (i_fault),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_ack      (d_ack),
    .d_rdata    (d_rdata),
    .d_fault    (d_fault),
    .flush      (flush),
    .m_req      (m_req),
    .m_we       (m_we),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_ready    (m_ready),
    .m_rdata    (m_rdata),
    .m_fault    (m_fault),
    .stall_IMEM (stall_IMEM),
    .stall_DMEM (stall_DMEM)
  );

  // flush_mode: 0 none, 1 flush held while waiting, 2 flush together with m_ready.
  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    int          flush_mode;
    logic [31:0] m_rdata;
    logic        m_fault;
    logic        exp_m_we;
    logic [31:0] exp_rdata;
    logic        exp_fault;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Waits (bounded) for m_req; returns the number of extra falling edges waited.
  task automatic wait_mreq(output bit seen, output int waited);
    seen   = 1'b0;
    waited = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (m_req) begin
        seen = 1'b1;
        break;
      end
      waited++;
    end
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    bit seen;
    int waited;
    logic ack_own, ack_oth, stall_own;
    logic [31:0] rdata_own;
    logic fault_own;
    @(negedge clk);
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      i_req = 1'b1; i_addr = v.addr; d_we = 1'b1;  // d_we must not leak into IMEM writes
    end
    wait_mreq(seen, waited);
    chk({tag, " m_req_latency"}, 32'(waited), 32'd0);
    if (!seen) begin
      i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      return;
    end
    chk({tag, " m_addr"}, m_addr, v.addr);
    chk({tag, " m_we"}, 32'(m_we), 32'(v.exp_m_we));
    if (v.is_d) chk({tag, " m_wdata"}, m_wdata, v.wdata);
    for (int c = 0; c < v.lat; c++) begin
      stall_own = v.is_d ? stall_DMEM : stall_IMEM;
      chk({tag, " stall_wait"}, 32'(stall_own), 32'd1);
      flush = (v.flush_mode == 1);
      @(negedge clk);
      chk({tag, " m_req_hold"}, 32'(m_req), 32'd1);
      chk({tag, " m_addr_hold"}, m_addr, v.addr);
    end
    m_ready = 1'b1; m_rdata = v.m_rdata; m_fault = v.m_fault;
    flush = (v.flush_mode == 2);
    @(negedge clk);
    m_ready = 1'b0; m_rdata = 32'hA5A5_5A5A; m_fault = 1'b0; flush = 1'b0;
    ack_own   = v.is_d ? d_ack : i_ack;
    ack_oth   = v.is_d ? i_ack : d_ack;
    rdata_own = v.is_d ? d_rdata : i_rdata;
    fault_own = v.is_d ? d_fault : i_fault;
    stall_own = v.is_d ? stall_DMEM : stall_IMEM;
    chk({tag, " ack"}, 32'(ack_own), 32'd1);
    chk({tag, " other_ack"}, 32'(ack_oth), 32'd0);
    chk({tag, " rdata"}, rdata_own, v.exp_rdata);
    chk({tag, " fault"}, 32'(fault_own), 32'(v.exp_fault));
    chk({tag, " m_req_drop"}, 32'(m_req), 32'd0);
    chk({tag, " stall_at_ack"}, 32'(stall_own), 32'd0);
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    ack_own = v.is_d ? d_ack : i_ack;
    chk({tag, " ack_one_cycle"}, 32'(ack_own), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    bit    seen;
    int    waited;
    string exp_order;
    byte   got_ch;
    byte   exp_ch;

    // Fields: is_d we addr wdata lat flush_mode m_rdata m_fault exp_m_we exp_rdata exp_fault
    vecs[0] = '{1'b0, 1'b0, 32'h0000_1000, 32'h0, 3, 0, 32'hDEAD_BEEF, 1'b0, 1'b0,
                32'hDEAD_BEEF, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_2000, 32'h0, 1, 0, 32'h1234_5678, 1'b0, 1'b0,
                32'h1234_5678, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_3000, 32'h55, 2, 0, 32'h0000_AAAA, 1'b1, 1'b1,
                32'h0, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0, 0, 0, 32'h0000_FFFF, 1'b1, 1'b0,
                32'h0, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 32'hCAFE_F00D, 2, 1, 32'h0BAD_F00D, 1'b0, 1'b1,
                32'h0BAD_F00D, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 32'h0000_0004, 32'h0, 5, 2, 32'h1357_9BDF, 1'b0, 1'b0,
                32'h1357_9BDF, 1'b0};

    rst = 1'b1;
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    flush = 1'b0; m_ready = 1'b0; m_rdata = '0; m_fault = 1'b0;

    // Reset state.
    #3;
    chk("rst m_req", 32'(m_req), 32'd0);
    chk("rst m_addr", m_addr, 32'd0);
    chk("rst m_wdata", m_wdata, 32'd0);
    chk("rst m_we", 32'(m_we), 32'd0);
    chk("rst i_ack", 32'(i_ack), 32'd0);
    chk("rst d_ack", 32'(d_ack), 32'd0);
    chk("rst i_rdata", i_rdata, 32'd0);
    chk("rst d_fault", 32'(d_fault), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 6; k++) begin
      apply_vec(vecs[k], $sformatf("vec%0d", k));
    end

    // Continuous contention: DMEM wins until IMEM has been skipped STARVE_LIMIT times.
    exp_order = "DDDDID";
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h0000_0100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0200;
    for (int t = 0; t < 6; t++) begin
      exp_ch = exp_order[t];
      wait_mreq(seen, waited);
      if (!seen) begin
        chk($sformatf("starve grant%0d seen", t), 32'(seen), 32'd1);
        break;
      end
      chk($sformatf("starve grant%0d addr", t), m_addr,
          (exp_ch == "D") ? 32'h0000_0200 : 32'h0000_0100);
      m_ready = 1'b1; m_rdata = 32'(t); m_fault = 1'b0;
      @(negedge clk);
      m_ready = 1'b0;
      if (d_ack && !i_ack) got_ch = "D";
      else if (i_ack && !d_ack) got_ch = "I";
      else got_ch = "?";
      chk($sformatf("starve grant%0d owner", t), 32'(got_ch), 32'(exp_ch));
    end
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);

    // Flush in IDLE blocks an IMEM grant.
    @(negedge clk);
    flush = 1'b1; i_req = 1'b1; i_addr = 32'h0000_0800;
    @(negedge clk);
    chk("flush_idle no_grant", 32'(m_req), 32'd0);
    flush = 1'b0;
    @(negedge clk);
    chk("flush_idle grant_after", 32'(m_req), 32'd1);
    // Flush one cycle after grant: drain without i_ack.
    flush = 1'b1; i_req = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    chk("drain m_req_hold", 32'(m_req), 32'd1);
    chk("drain i_ack", 32'(i_ack), 32'd0);
    @(negedge clk);
    chk("drain m_req_hold2", 32'(m_req), 32'd1);
    m_ready = 1'b1; m_rdata = 32'h0000_0BAD;
    @(negedge clk);
    m_ready = 1'b0;
    chk("drain m_req_drop", 32'(m_req), 32'd0);
    chk("drain no_i_ack", 32'(i_ack), 32'd0);
    @(negedge clk);
    chk("drain no_i_ack_late", 32'(i_ack), 32'd0);
    apply_vec(vecs[1], "post_flush");

    // Reset while DMEM owns the port.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0300; d_wdata = 32'h77;
    wait_mreq(seen, waited);
    chk("rst_mid grant", 32'(seen), 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid m_req", 32'(m_req), 32'd0);
    chk("rst_mid m_addr", m_addr, 32'd0);
    chk("rst_mid m_we", 32'(m_we), 32'd0);
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_ready = 1'b1; m_rdata = 32'h0000_0099;
    @(negedge clk);
    m_ready = 1'b0;
    chk("rst_mid late_ready d_ack", 32'(d_ack), 32'd0);
    chk("rst_mid late_ready i_ack", 32'(i_ack), 32'd0);
    chk("rst_mid late_ready m_req", 32'(m_req), 32'd0);
    chk("rst_mid d_rdata", d_rdata, 32'd0);

`ifdef ARB_TIMEOUT_EN
    // Watchdog: m_ready never arrives.
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h0000_5000;
    wait_mreq(seen, waited);
    chk("timeout grant", 32'(seen), 32'd1);
    waited = 0;
    for (int c = 0; c < 20; c++) begin
      if (!m_req) break;
      waited++;
      @(negedge clk);
    end
    chk("timeout m_req_cycles", 32'(waited), 32'd8);
    chk("timeout i_ack", 32'(i_ack), 32'd1);
    chk("timeout i_fault", 32'(i_fault), 32'd1);
    chk("timeout i_rdata", i_rdata, 32'd0);
    i_req = 1'b0;
    @(negedge clk);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
